weight_g_to_kg: RTL and testbench
=================================

// Module: weight_g_to_kg
// PURPOSE
//  Converts a binary weight in grams to kilograms, as an integer part and a
//  fractional part in grams: grams/1000 and grams%1000. Sits between the
//  scale's gram accumulator and the display formatter.
//  Uses an iterative restoring divider (one quotient bit per clock) with a
//  start/done handshake.
// PARAMETERS
//  WIDTH    14    width of input, quotient and remainder buses
//  DIVISOR  1000  grams per kilogram; constant, must be >0 and < 2**WIDTH
// PORTS
//  clk                        in   1      system clock, rising edge
//  reset                      in   1      asynchronous, active-high reset
//  start                      in   1      request conversion of weightInGrams
//  weightInGrams              in   WIDTH  unsigned weight in grams (0..16383)
//  busy                       out  1      conversion in progress
//  done                       out  1      one-cycle pulse: outputs just updated
//  weightInKilogramsInteger   out  WIDTH  floor(grams/DIVISOR)
//  weightInKilogramsFraction  out  WIDTH  grams mod DIVISOR (0..999)
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous, active-high.
//  - Reset, including mid-conversion: state IDLE; busy=0, done=0; both
//    results = 0; internal quotient/remainder/count cleared. An aborted
//    conversion never produces done.
//  - States: IDLE, CALC, DONE.
//  - IDLE or DONE, start=1 at edge E0: capture weightInGrams, clear the
//    partial remainder, go to CALC, busy=1.
//    In DONE this is a back-to-back start.
//  - start is ignored in CALC; the captured operand is unaffected by later
//    input changes.
//  - CALC runs WIDTH iterations, MSB first, on edges E1..E14:
//    - Shift the next dividend bit into the remainder.
//    - If remainder >= DIVISOR: subtract DIVISOR, quotient bit = 1;
//      otherwise quotient bit = 0.
//  - At edge E14 both outputs are registered, state goes to DONE, busy=0 and
//    done=1. done is therefore high exactly 14 cycles after the start edge.
//  - DONE lasts one cycle, then goes to IDLE (or to CALC if start=1).
//  - Outputs hold their last result until the next completion or reset; they
//    never show partial values.
//  - Result ranges:
//    - integer output 0..16; bits above bit 4 are always 0.
//    - fraction output 0..999; bits above bit 9 are always 0.
//  - Remainder datapath is WIDTH+1 bits wide to avoid overflow on the
//    compare/subtract.
//  - No rounding; pure truncating division.
//  - Invariant: integer*DIVISOR + fraction == captured grams.
// TESTING
//  - Reset: assert reset mid-CALC -> busy=0, done=0, outputs 0 immediately;
//    no done afterwards.
//  - 1500 g (14'b00010111011100), start pulse -> done 14 cycles later;
//    integer=1, fraction=500.
//  - Boundaries:
//    - 0 -> 0/0
//    - 999 -> 0/999
//    - 1000 -> 1/0
//    - 16383 -> 16/383
//  - start asserted while busy, with input changed to 2000 -> ignored;
//    the first result (1/500) is still delivered.
//  - Back-to-back: start=1 during the done cycle with 7250 -> second done
//    14 cycles later with 7/250.
//  - Random sweep of 1000 values checked against grams/1000 and grams%1000;
//    done is a single-cycle pulse each time.

Source files
------------

// File: rtl/weight_g_to_kg.sv
// Gram-to-kilogram converter: iterative restoring divide by DIVISOR, one quotient
// bit per clock, with a start/busy/done handshake and registered results.
module weight_g_to_kg #(
    parameter int WIDTH   = 14,
    parameter int DIVISOR = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] weightInGrams,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] weightInKilogramsInteger,
    output logic [WIDTH-1:0] weightInKilogramsFraction
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0]  DIV  = (WIDTH + 1)'(DIVISOR);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH:0]   remainder;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic             q_bit;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        rem_shift = (remainder << 1) | {{WIDTH{1'b0}}, dividend[WIDTH-1]};
        q_bit     = (rem_shift >= DIV);
        rem_next  = q_bit ? (rem_shift - DIV) : rem_shift;
        quot_next = (quotient << 1) | WIDTH'(q_bit);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            dividend                  <= '0;
            quotient                  <= '0;
            remainder                 <= '0;
            count                     <= '0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            weightInKilogramsInteger  <= '0;
            weightInKilogramsFraction <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dividend  <= weightInGrams;
                        quotient  <= '0;
                        remainder <= '0;
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    dividend  <= dividend << 1;
                    remainder <= rem_next;
                    quotient  <= quot_next;
                    count     <= count + CW'(1);
                    // Last bit: publish results directly so outputs never show partials.
                    if (count == LAST) begin
                        weightInKilogramsInteger  <= quot_next;
                        weightInKilogramsFraction <= rem_next[WIDTH-1:0];
                        busy                      <= 1'b0;
                        done                      <= 1'b1;
                        state                     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_g_to_kg.sv
// Self-checking bench for weight_g_to_kg: cycle-level behavioural model plus
// directed boundary cases and a randomized sweep.
module tb_weight_g_to_kg;

    localparam int WIDTH   = 14;
    localparam int DIVISOR = 1000;
    localparam int LATENCY = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] weight;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] kg_int;
    logic [WIDTH-1:0] kg_frac;

    int n_checks = 0;
    int n_errors = 0;

    weight_g_to_kg #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .weightInGrams             (weight),
        .busy                      (busy),
        .done                      (done),
        .weightInKilogramsInteger  (kg_int),
        .weightInKilogramsFraction (kg_frac)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: an accepted start launches a countdown; on expiry the
    // results are plain integer division and modulo of the captured grams.
    bit m_busy, m_done;
    int m_left, m_op, m_int, m_frac;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_left = 0; m_int = 0; m_frac = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_int  = m_op / DIVISOR;
                m_frac = m_op % DIVISOR;
            end
        end else begin
            m_done = 0;
            if (start === 1'b1) begin
                m_op   = int'(weight);
                m_busy = 1;
                m_left = LATENCY;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_busy));
        check("done", int'(done), int'(m_done));
        check("kg_int", int'(kg_int), m_int);
        check("kg_frac", int'(kg_frac), m_frac);
    end

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < LATENCY + 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic convert(input int g, output bit ok);
        start  = 1'b1;
        weight = WIDTH'(g);
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
    endtask

    task automatic convert_expect(input string name, input int g, input int e_int, input int e_frac);
        bit ok;
        convert(g, ok);
        if (ok) begin
            check({name, "_int"}, int'(kg_int), e_int);
            check({name, "_frac"}, int'(kg_frac), e_frac);
        end
    endtask

    initial begin
        bit ok;
        int g, seen;
        reset  = 1'b1;
        start  = 1'b0;
        weight = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_int", int'(kg_int), 0);
        reset = 1'b0;
        @(negedge clk);

        convert_expect("g1500", 1500, 1, 500);
        @(negedge clk);

        // Abort mid-conversion: outputs clear at once and no done follows.
        start = 1'b1; weight = WIDTH'(7250);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_int", int'(kg_int), 0);
        check("abort_frac", int'(kg_frac), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);

        convert_expect("g0", 0, 0, 0);
        convert_expect("g999", 999, 0, 999);
        convert_expect("g1000", 1000, 1, 0);
        convert_expect("g16383", 16383, 16, 383);
        @(negedge clk);

        // start while busy with a new operand is ignored.
        start = 1'b1; weight = WIDTH'(1500);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; weight = WIDTH'(2000);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        if (ok) begin
            check("ignore_int", int'(kg_int), 1);
            check("ignore_frac", int'(kg_frac), 500);
        end

        // Back-to-back: start during the done cycle.
        convert_expect("b2b_first", 1500, 1, 500);
        convert_expect("b2b_second", 7250, 7, 250);

        for (int n = 0; n < 1000; n++) begin
            g = int'($urandom_range(0, 16383));
            convert(g, ok);
            if (ok) begin
                check("rand_int", int'(kg_int), g / 1000);
                check("rand_frac", int'(kg_frac), g % 1000);
                check("rand_invariant", int'(kg_int) * 1000 + int'(kg_frac), g);
            end
            // Sometimes restart in the done cycle, otherwise idle a little.
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
